uart_io_ctrl: RTL and testbench



---
 rtl/uart_io_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_io_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_ctrl.sv
// CPU-side UART I/O controller: RX FIFO with irr/ack handshake,
// TX FIFO feeding the transmitter one byte per start pulse.
module uart_io_ctrl #(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       irr,
    output logic [7:0] rx_data,
    input  logic       ack,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       uart_tx_start,
    output logic [7:0] uart_tx_data,
    input  logic       uart_tx_busy,
    output logic       rx_overflow,
    output logic       tx_overflow
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);
    localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    logic           r_ack_q;
    logic           r_req_q;
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [RAW-1:0] r_rx_wr;
    logic [RAW-1:0] r_rx_rd;
    logic [RCW-1:0] r_rx_cnt;
    logic           r_rx_ovf;
    logic [7:0]     r_tx_mem [TX_DEPTH];
    logic [TAW-1:0] r_tx_wr;
    logic [TAW-1:0] r_tx_rd;
    logic [TCW-1:0] r_tx_cnt;
    logic           r_tx_ovf;
    logic           r_start;
    logic [7:0]     r_tx_data;
    logic           r_wait;
    state_t         r_state;
    state_t         w_next;

    logic w_ack_rise;
    logic w_req_rise;
    logic w_rx_full;
    logic w_rx_pop;
    logic w_rx_push;
    logic w_tx_full;
    logic w_tx_pop;
    logic w_tx_push;

    assign w_ack_rise = ack & ~r_ack_q;
    assign w_req_rise = tx_req & ~r_req_q;
    assign w_rx_full  = (r_rx_cnt == RX_FULL);
    assign w_rx_pop   = w_ack_rise & (r_rx_cnt != '0);
    assign w_rx_push  = rx_valid & (~w_rx_full | w_rx_pop);
    assign w_tx_full  = (r_tx_cnt == TX_FULL);
    assign w_tx_push  = w_req_rise & (~w_tx_full | w_tx_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack_q <= 1'b0;
            r_req_q <= 1'b0;
        end else begin
            r_ack_q <= ack;
            r_req_q <= tx_req;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_byte;
        if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + RAW'(1);
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + RAW'(1);
            r_rx_cnt <= r_rx_cnt + RCW'(w_rx_push) - RCW'(w_rx_pop);
            if (rx_valid && !w_rx_push) r_rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + TAW'(1);
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + TAW'(1);
            r_tx_cnt <= r_tx_cnt + TCW'(w_tx_push) - TCW'(w_tx_pop);
            if (w_req_rise && !w_tx_push) r_tx_ovf <= 1'b1;
        end
    end

    // r_wait marks the second WAIT_HI cycle; a silent transmitter times out there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wait    <= 1'b0;
            r_start   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_state <= w_next;
            r_wait  <= (r_state == WAIT_HI);
            r_start <= w_tx_pop;
            if (w_tx_pop) r_tx_data <= r_tx_mem[r_tx_rd];
        end
    end

    always_comb begin
        w_next   = r_state;
        w_tx_pop = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_tx_cnt != '0 && !uart_tx_busy) begin
                    w_tx_pop = 1'b1;
                    w_next   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (uart_tx_busy) w_next = WAIT_LO;
                else if (r_wait)  w_next = IDLE;
            end
            WAIT_LO: begin
                if (!uart_tx_busy) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign irr           = (r_rx_cnt != '0);
    assign rx_data       = irr ? r_rx_mem[r_rx_rd] : 8'h00;
    assign tx_busy       = w_tx_full;
    assign uart_tx_start = r_start;
    assign uart_tx_data  = r_tx_data;
    assign rx_overflow   = r_rx_ovf;
    assign tx_overflow   = r_tx_ovf;
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl with a behavioural transmitter model.
module tb_uart_io_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       irr;
    logic [7:0] rx_data;
    logic       ack;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       uart_tx_start;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
    logic       rx_overflow;
    logic       tx_overflow;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mode   = 0;
    int bcnt   = 0;
    int viol   = 0;
    int sbase;
    int vbase;
    logic [7:0] sq[$];
    int         st[$];

    uart_io_ctrl #(.RX_DEPTH(8), .TX_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .irr(irr), .rx_data(rx_data), .ack(ack),
        .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy),
        .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy),
        .rx_overflow(rx_overflow), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    // mode 0: busy 10 cycles after each start; 1: never busy; 2: stuck busy
    assign uart_tx_busy = (mode == 2) ? 1'b1 :
                          (mode == 1) ? 1'b0 : (bcnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_tx_start) begin
            sq.push_back(uart_tx_data);
            st.push_back(cyc);
            if (uart_tx_busy) viol <= viol + 1;
            bcnt <= 10;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        tick(2);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data = b;
        tx_req  = 1'b1;
        tick(1);
        tx_req  = 1'b0;
        tick(1);
    endtask

    initial begin
        reset = 1'b1;
        rx_valid = 1'b0; rx_byte = 8'h00; ack = 1'b0;
        tx_req = 1'b0; tx_data = 8'h00;
        tick(3);
        check("rst_irr", irr, 0);
        check("rst_start", uart_tx_start, 0);
        reset = 1'b0;
        tick(1);
        check("idle_irr", irr, 0);
        check("idle_rxd", rx_data, 0);
        check("idle_txbusy", tx_busy, 0);
        check("idle_start", uart_tx_start, 0);
        check("idle_txd", uart_tx_data, 0);
        check("idle_rxovf", rx_overflow, 0);
        check("idle_txovf", tx_overflow, 0);
        repeat (5) ack_pulse();
        check("ack_empty_irr", irr, 0);
        check("ack_empty_ovf", rx_overflow, 0);

        rx_valid = 1'b1; rx_byte = 8'h41;
        tick(1);
        rx_valid = 1'b0;
        check("rx_lat_irr", irr, 1);
        check("rx_head0", rx_data, 8'h41);
        push_rx(8'h42);
        push_rx(8'h43);
        check("rx_head0b", rx_data, 8'h41);
        ack = 1'b1;
        tick(1);
        check("rx_pop1", rx_data, 8'h42);
        tick(3);
        check("rx_hold", rx_data, 8'h42);
        ack = 1'b0;
        tick(1);
        ack = 1'b1;
        tick(1);
        check("rx_pop2", rx_data, 8'h43);
        ack = 1'b0;
        tick(3);
        ack = 1'b1;
        tick(1);
        check("rx_pop3_irr", irr, 0);
        check("rx_pop3_rxd", rx_data, 0);
        ack = 1'b0;
        tick(3);

        for (int i = 0; i < 9; i++) push_rx(8'h50 + 8'(i));
        check("ovf_flag", rx_overflow, 1);
        check("ovf_head", rx_data, 8'h50);
        rx_valid = 1'b1; rx_byte = 8'h59; ack = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        check("full_pp_head", rx_data, 8'h51);
        ack = 1'b0;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            check("drain_irr", irr, 1);
            check("drain_data", rx_data, (i < 7) ? 32'h51 + 32'(i) : 32'h59);
            ack_pulse();
        end
        check("drain_empty", irr, 0);
        check("ovf_sticky", rx_overflow, 1);

        mode = 0;
        sbase = sq.size();
        vbase = viol;
        tx_data = 8'h10; tx_req = 1'b1;
        tick(1);
        check("tx_lat1", uart_tx_start, 0);
        tx_req = 1'b0;
        tick(1);
        check("tx_lat2", uart_tx_start, 1);
        check("tx_lat2_data", uart_tx_data, 8'h10);
        tx_data = 8'h20; tx_req = 1'b1;
        tick(1);
        tx_req = 1'b0;
        tick(40);
        check("drain_starts", sq.size() - sbase, 2);
        check("drain_b0", sq[sbase], 8'h10);
        check("drain_b1", sq[sbase+1], 8'h20);
        check("drain_busyviol", viol - vbase, 0);
        check("drain_txovf", tx_overflow, 0);

        mode = 2;
        sbase = sq.size();
        for (int i = 0; i < 8; i++) push_tx(8'h80 + 8'(i));
        check("txfull_busy", tx_busy, 1);
        check("txfull_noovf", tx_overflow, 0);
        push_tx(8'h88);
        check("txfull_ovf", tx_overflow, 1);
        check("txfull_busy2", tx_busy, 1);
        mode = 0;
        tick(150);
        check("txfull_starts", sq.size() - sbase, 8);
        for (int i = 0; i < 8; i++)
            check("txfull_order", sq[sbase+i], 32'h80 + 32'(i));
        check("txfull_empty", tx_busy, 0);
        check("txfull_sticky", tx_overflow, 1);

        mode = 1;
        sbase = sq.size();
        push_tx(8'hA1);
        push_tx(8'hA2);
        push_tx(8'hA3);
        tick(20);
        check("silent_starts", sq.size() - sbase, 3);
        check("silent_b0", sq[sbase], 8'hA1);
        check("silent_b1", sq[sbase+1], 8'hA2);
        check("silent_b2", sq[sbase+2], 8'hA3);
        check("silent_gap1", st[sbase+1] - st[sbase], 3);
        check("silent_gap2", st[sbase+2] - st[sbase+1], 3);

        mode = 0;
        sbase = sq.size();
        push_tx(8'hB1);
        push_tx(8'hB2);
        push_tx(8'hB3);
        push_tx(8'hB4);
        check("wlo_busy", uart_tx_busy, 1);
        reset = 1'b1;
        #1;
        check("wlo_rst_start", uart_tx_start, 0);
        check("wlo_rst_txd", uart_tx_data, 0);
        check("wlo_rst_txovf", tx_overflow, 0);
        check("wlo_rst_rxovf", rx_overflow, 0);
        tick(2);
        reset = 1'b0;
        tick(30);
        check("wlo_starts", sq.size() - sbase, 1);
        check("wlo_b0", sq[sbase], 8'hB1);

        mode = 1;
        push_tx(8'hC1);
        check("async_pre", uart_tx_start, 1);
        reset = 1'b1;
        #1;
        check("async_start", uart_tx_start, 0);
        check("async_txd", uart_tx_data, 0);
        tx_data = 8'hD5; tx_req = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("lvl_edge_start", uart_tx_start, 1);
        check("lvl_edge_data", uart_tx_data, 8'hD5);
        tx_req = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
